// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: fetch PC, imem request/response tracking,
// a small instruction buffer toward decode, and redirect/reset flushing.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/ready/addr       word request channel (addr[1:0]=00)
//   imem_rsp_valid/data             in-order responses, one per request
//   redirect_valid/pc               branch/jump restart (pc[1:0] ignored)
//   instr_valid/ready, instr/pc     buffer head toward the decoder
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] DEPTH = 32'(FIFO_DEPTH);
    localparam logic [31:0] MAXO  = 32'(MAX_OUTSTANDING);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_data [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];

    logic [OW-1:0] live;
    logic [OW-1:0] outstanding_next;
    logic          credit_ok;
    logic          req_fire;
    logic          push;
    logic          drop;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A request only goes out if its word is guaranteed a buffer slot,
    // counting words already buffered and live requests still in flight.
    assign live      = outstanding - discard;
    assign credit_ok = (32'(count) + 32'(live)) < DEPTH;

    assign imem_req_valid = !rst && !redirect_valid && credit_ok &&
                            (32'(outstanding) < MAXO);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign drop = imem_rsp_valid && (discard != '0);
    assign push = imem_rsp_valid && (discard == '0);

    assign instr_valid = !rst && (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? buf_data[rd_ptr] : NOP;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr] : '0;

    assign outstanding_next = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);

    // Memory is not reset with us, so requests in flight at reset or
    // redirect are still counted; all of them are marked for discard,
    // which leaves zero live requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding_next;
            discard     <= outstanding_next;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            rsp_pc      <= {redirect_pc[31:2], 2'b00};
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= outstanding_next;
            discard     <= outstanding_next;
        end else begin
            outstanding <= outstanding_next;
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (drop) begin
                discard <= discard - OW'(1);
            end
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !rst && !redirect_valid) begin
            buf_data[wr_ptr] <= imem_rsp_data;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule
